// File: rtl/ncu_mcu_pkg.sv
// Shared constants, field lengths and FSM state types for the NCU<->MCU 4-bit CSR link.
package ncu_mcu_pkg;

  localparam int unsigned NIB_W    = 4;
  localparam int unsigned TAG_NIB  = 2;
  localparam int unsigned ADDR_NIB = 10;
  localparam int unsigned DATA_NIB = 16;
  localparam int unsigned TAG_W    = TAG_NIB * NIB_W;
  localparam int unsigned ADDR_W   = ADDR_NIB * NIB_W;
  localparam int unsigned DATA_W   = DATA_NIB * NIB_W;
  localparam int unsigned PKT_W    = NIB_W + TAG_W + DATA_W;
  localparam int unsigned CNT_W    = 5;

  localparam logic [NIB_W-1:0] CMD_READ  = 4'b0100;
  localparam logic [NIB_W-1:0] CMD_WRITE = 4'b0101;
  localparam logic [NIB_W-1:0] CMD_IFILL = 4'b0110;

  localparam logic [NIB_W-1:0] RSP_READ_ACK   = 4'b0001;
  localparam logic [NIB_W-1:0] RSP_READ_NACK  = 4'b0000;
  localparam logic [NIB_W-1:0] RSP_IFILL_ACK  = 4'b0011;
  localparam logic [NIB_W-1:0] RSP_IFILL_NACK = 4'b0111;

  typedef enum logic [2:0] {R_IDLE, R_TAG, R_ADDR, R_WDATA, R_EXEC} rx_state_t;
  typedef enum logic [2:0] {T_IDLE, T_WAIT, T_HDR, T_TAG, T_DATA} tx_state_t;

  // Upstream packet image, header nibble in the MSBs so it leaves first
  typedef struct packed {
    logic [NIB_W-1:0]  hdr;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } resp_pkt_t;

  function automatic logic is_req_cmd(input logic [NIB_W-1:0] c);
    return (c == CMD_READ) || (c == CMD_WRITE) || (c == CMD_IFILL);
  endfunction

endpackage

// File: rtl/ncu_mcu_csr_resp_if.sv
// NCU<->MCU 4-bit link: downstream request stream, upstream response stream, stalls both ways.
interface ncu_mcu_csr_resp_if;

  logic                           ncu_mcu_vld;
  logic [ncu_mcu_pkg::NIB_W-1:0]  ncu_mcu_data;
  logic                           ncu_mcu_stall;
  logic                           mcu_ncu_vld;
  logic [ncu_mcu_pkg::NIB_W-1:0]  mcu_ncu_data;
  logic                           mcu_ncu_stall;

  modport master (
    output ncu_mcu_vld, ncu_mcu_data, ncu_mcu_stall,
    input  mcu_ncu_vld, mcu_ncu_data, mcu_ncu_stall
  );

  modport slave (
    input  ncu_mcu_vld, ncu_mcu_data, ncu_mcu_stall,
    output mcu_ncu_vld, mcu_ncu_data, mcu_ncu_stall
  );

endinterface

// File: rtl/ncu_mcu_nib_ser.sv
// Loadable shift register emitting the upstream packet one nibble per cycle, MSB nibble first.
module ncu_mcu_nib_ser
  import ncu_mcu_pkg::*;
(
  input  logic             iol2clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             clear,
  input  resp_pkt_t        pkt,
  output logic [NIB_W-1:0] nib
);

  logic [PKT_W-1:0] sr_q;
  logic [PKT_W-1:0] src;

  // load+shift in one cycle emits the header straight from the new image
  assign src = load ? pkt : sr_q;

  always_ff @(posedge iol2clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
      nib  <= '0;
    end else begin
      if (load || shift) begin
        sr_q <= shift ? {src[PKT_W-NIB_W-1:0], NIB_W'(0)} : src;
      end
      if (shift) begin
        nib <= src[PKT_W-1 -: NIB_W];
      end else if (clear) begin
        nib <= '0;
      end
    end
  end

endmodule

// File: rtl/ncu_mcu_csr_resp.sv
// MCU-side CSR responder: deserializes NCU requests into a 64-bit CSR file and returns READ/IFILL responses.
module ncu_mcu_csr_resp
  import ncu_mcu_pkg::*;
#(
  parameter int unsigned       NREG      = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = 64'h0
) (
  input  logic                iol2clk,
  input  logic                rst,
  ncu_mcu_csr_resp_if.slave   bus,
  output logic [7:0]          err_cnt
);

  localparam int unsigned IDX_W = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int unsigned AHI_W = ADDR_W - 3;

  rx_state_t         rx_q, rx_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [NIB_W-1:0]  cmd_q, cmd_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rx_err, rx_last, rx_rd_last;

  tx_state_t         tx_q, tx_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic              tx_ack_q;
  logic              ser_load, ser_shift, ser_clear, tx_done;
  logic              vld_q, vld_d;
  logic [NIB_W-1:0]  tx_nib;

  logic              stall_q, stall_d;
  logic              err_inc;
  logic [DATA_W-1:0] csr_q [NREG];

  logic [NIB_W-1:0]  nib;
  logic              exec, is_wr, addr_ok;
  logic [IDX_W-1:0]  idx;
  resp_pkt_t         resp;

  assign nib     = bus.ncu_mcu_data;
  assign exec    = (rx_q == R_EXEC);
  assign is_wr   = (cmd_q == CMD_WRITE);
  assign addr_ok = (addr_q[2:0] == 3'b000) && (addr_q[ADDR_W-1:3] < AHI_W'(NREG));
  assign idx     = addr_q[3 +: IDX_W];

  // RX next-state: a header always preempts, except while busy when it is dropped
  always_comb begin
    rx_d       = rx_q;
    rx_cnt_d   = rx_cnt_q;
    cmd_d      = cmd_q;
    tag_d      = tag_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rx_err     = 1'b0;
    rx_last    = 1'b0;
    rx_rd_last = 1'b0;
    if (bus.ncu_mcu_vld) begin
      if (stall_q) begin
        rx_err = 1'b1;
        rx_d   = R_IDLE;
      end else begin
        rx_err = (rx_q != R_IDLE) || !is_req_cmd(nib);
        if (is_req_cmd(nib)) begin
          rx_d     = R_TAG;
          rx_cnt_d = CNT_W'(TAG_NIB - 1);
          cmd_d    = nib;
        end else begin
          rx_d = R_IDLE;
        end
      end
    end else begin
      unique case (rx_q)
        R_TAG: begin
          tag_d = {tag_q[TAG_W-NIB_W-1:0], nib};
          if (rx_cnt_q == '0) begin
            rx_d     = R_ADDR;
            rx_cnt_d = CNT_W'(ADDR_NIB - 1);
          end else begin
            rx_cnt_d = rx_cnt_q - CNT_W'(1);
          end
        end
        R_ADDR: begin
          addr_d = {addr_q[ADDR_W-NIB_W-1:0], nib};
          if (rx_cnt_q == '0) begin
            if (is_wr) begin
              rx_d     = R_WDATA;
              rx_cnt_d = CNT_W'(DATA_NIB - 1);
            end else begin
              rx_d       = R_EXEC;
              rx_last    = 1'b1;
              rx_rd_last = 1'b1;
            end
          end else begin
            rx_cnt_d = rx_cnt_q - CNT_W'(1);
          end
        end
        R_WDATA: begin
          wdata_d = {wdata_q[DATA_W-NIB_W-1:0], nib};
          if (rx_cnt_q == '0) begin
            rx_d    = R_EXEC;
            rx_last = 1'b1;
          end else begin
            rx_cnt_d = rx_cnt_q - CNT_W'(1);
          end
        end
        R_EXEC:  rx_d = R_IDLE;
        default: rx_d = R_IDLE;
      endcase
    end
  end

  always_ff @(posedge iol2clk or posedge rst) begin
    if (rst) begin
      rx_q     <= R_IDLE;
      rx_cnt_q <= '0;
      cmd_q    <= '0;
      tag_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      rx_q     <= rx_d;
      rx_cnt_q <= rx_cnt_d;
      cmd_q    <= cmd_d;
      tag_q    <= tag_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // CSR file: written at the end of a valid WRITE's execute cycle
  always_ff @(posedge iol2clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) csr_q[i] <= RESET_VAL;
    end else if (exec && is_wr && addr_ok) begin
      csr_q[idx] <= wdata_q;
    end
  end

  always_comb begin
    resp.tag  = tag_q;
    resp.data = addr_ok ? csr_q[idx] : '0;
    if (cmd_q == CMD_IFILL) resp.hdr = addr_ok ? RSP_IFILL_ACK : RSP_IFILL_NACK;
    else                    resp.hdr = addr_ok ? RSP_READ_ACK  : RSP_READ_NACK;
  end

  // TX next-state: T_WAIT coincides with R_EXEC so the header can leave one cycle later
  always_comb begin
    tx_d      = tx_q;
    tx_cnt_d  = tx_cnt_q;
    ser_load  = 1'b0;
    ser_shift = 1'b0;
    ser_clear = 1'b0;
    vld_d     = 1'b0;
    tx_done   = 1'b0;
    unique case (tx_q)
      T_IDLE: if (rx_rd_last) tx_d = T_WAIT;
      T_WAIT: begin
        ser_load = exec;
        if (!bus.ncu_mcu_stall) begin
          ser_shift = 1'b1;
          vld_d     = 1'b1;
          tx_d      = T_HDR;
        end
      end
      T_HDR: begin
        ser_shift = 1'b1;
        tx_d      = T_TAG;
        tx_cnt_d  = CNT_W'(TAG_NIB - 1);
      end
      T_TAG: begin
        if (tx_cnt_q != '0) begin
          ser_shift = 1'b1;
          tx_cnt_d  = tx_cnt_q - CNT_W'(1);
        end else if (tx_ack_q) begin
          ser_shift = 1'b1;
          tx_d      = T_DATA;
          tx_cnt_d  = CNT_W'(DATA_NIB - 1);
        end else begin
          ser_clear = 1'b1;
          tx_done   = 1'b1;
          tx_d      = T_IDLE;
        end
      end
      T_DATA: begin
        if (tx_cnt_q != '0) begin
          ser_shift = 1'b1;
          tx_cnt_d  = tx_cnt_q - CNT_W'(1);
        end else begin
          ser_clear = 1'b1;
          tx_done   = 1'b1;
          tx_d      = T_IDLE;
        end
      end
      default: tx_d = T_IDLE;
    endcase
  end

  always_ff @(posedge iol2clk or posedge rst) begin
    if (rst) begin
      tx_q     <= T_IDLE;
      tx_cnt_q <= '0;
      vld_q    <= 1'b0;
      tx_ack_q <= 1'b0;
    end else begin
      tx_q     <= tx_d;
      tx_cnt_q <= tx_cnt_d;
      vld_q    <= vld_d;
      if (exec && !is_wr) tx_ack_q <= addr_ok;
    end
  end

  ncu_mcu_nib_ser u_ser (
    .iol2clk (iol2clk),
    .rst     (rst),
    .load    (ser_load),
    .shift   (ser_shift),
    .clear   (ser_clear),
    .pkt     (resp),
    .nib     (tx_nib)
  );

  // Busy from the last request nibble until the write executes or the response drains
  always_comb begin
    stall_d = stall_q;
    if ((exec && is_wr) || tx_done) stall_d = 1'b0;
    if (rx_last) stall_d = 1'b1;
  end

  assign err_inc = rx_err || (exec && is_wr && !addr_ok);

  always_ff @(posedge iol2clk or posedge rst) begin
    if (rst) begin
      stall_q <= 1'b0;
      err_cnt <= '0;
    end else begin
      stall_q <= stall_d;
      if (err_inc && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

  assign bus.mcu_ncu_stall = stall_q;
  assign bus.mcu_ncu_vld   = vld_q;
  assign bus.mcu_ncu_data  = tx_nib;

endmodule

// File: tb/tb_ncu_mcu_csr_resp.sv
// Self-checking bench for ncu_mcu_csr_resp: directed scenarios plus randomized traffic against a packet-level model.
module tb_ncu_mcu_csr_resp;

  localparam int          NREG    = 8;
  localparam logic [63:0] RST_VAL = 64'h0123_4567_89AB_CDEF;
  localparam logic [3:0]  C_READ  = 4'b0100;
  localparam logic [3:0]  C_WRITE = 4'b0101;
  localparam logic [3:0]  C_IFILL = 4'b0110;

  logic       iol2clk = 1'b0;
  logic       rst;
  logic [7:0] err_cnt;

  ncu_mcu_csr_resp_if bus ();

  ncu_mcu_csr_resp #(.NREG(NREG), .RESET_VAL(RST_VAL)) dut (
    .iol2clk (iol2clk),
    .rst     (rst),
    .bus     (bus),
    .err_cnt (err_cnt)
  );

  always #5 iol2clk = ~iol2clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_csr [NREG];
  int          m_err;
  logic [3:0]  req_q [$];
  logic [3:0]  exp_q [$];

  task automatic step();
    @(posedge iol2clk);
    #1;
  endtask

  function automatic bit addr_valid(input logic [39:0] a);
    return (a % 40'd8 == 40'd0) && (a / 40'd8 < 40'(NREG));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_csr[i] = RST_VAL;
    m_err = 0;
  endtask

  task automatic bump_err();
    if (m_err < 255) m_err++;
  endtask

  task automatic build_req(input logic [3:0] cmd, input logic [7:0] tag,
                           input logic [39:0] addr, input logic [63:0] data);
    req_q.delete();
    req_q.push_back(cmd);
    for (int i = 1; i >= 0; i--) req_q.push_back(tag[i*4 +: 4]);
    for (int i = 9; i >= 0; i--) req_q.push_back(addr[i*4 +: 4]);
    if (cmd == C_WRITE) for (int i = 15; i >= 0; i--) req_q.push_back(data[i*4 +: 4]);
  endtask

  task automatic build_exp(input logic [3:0] cmd, input logic [7:0] tag, input logic [39:0] addr);
    bit ok;
    logic [63:0] d;
    ok = addr_valid(addr);
    exp_q.delete();
    if (cmd == C_IFILL) exp_q.push_back(ok ? 4'b0011 : 4'b0111);
    else                exp_q.push_back(ok ? 4'b0001 : 4'b0000);
    for (int i = 1; i >= 0; i--) exp_q.push_back(tag[i*4 +: 4]);
    if (ok) begin
      d = m_csr[int'(addr / 40'd8)];
      for (int i = 15; i >= 0; i--) exp_q.push_back(d[i*4 +: 4]);
    end
  endtask

  task automatic send_req(input int lim);
    for (int i = 0; i < req_q.size() && i < lim; i++) begin
      bus.ncu_mcu_vld  = (i == 0);
      bus.ncu_mcu_data = req_q[i];
      step();
    end
    bus.ncu_mcu_vld  = 1'b0;
    bus.ncu_mcu_data = 4'h0;
  endtask

  // Starts on the cycle after the last request nibble
  task automatic recv_resp(input string nm, input int hold, input int mid);
    for (int k = 0; k <= hold; k++) begin
      bus.ncu_mcu_stall = (k < hold);
      checks++;
      if (bus.mcu_ncu_vld !== 1'b0 || bus.mcu_ncu_stall !== 1'b1) begin
        errors++;
        $display("FAIL %s wait%0d: vld=%b stall=%b, required vld=0 stall=1",
                 nm, k, bus.mcu_ncu_vld, bus.mcu_ncu_stall);
      end
      step();
    end
    for (int n = 0; n < exp_q.size(); n++) begin
      bus.ncu_mcu_stall = (mid > 0 && n >= mid && n < mid + 3);
      checks++;
      if (bus.mcu_ncu_vld !== 1'(n == 0) || bus.mcu_ncu_data !== exp_q[n] ||
          bus.mcu_ncu_stall !== 1'b1) begin
        errors++;
        $display("FAIL %s nib%0d: vld=%b data=%h stall=%b, required vld=%b data=%h stall=1",
                 nm, n, bus.mcu_ncu_vld, bus.mcu_ncu_data, bus.mcu_ncu_stall, n == 0, exp_q[n]);
      end
      step();
    end
    bus.ncu_mcu_stall = 1'b0;
    checks++;
    if (bus.mcu_ncu_vld !== 1'b0 || bus.mcu_ncu_data !== 4'h0 || bus.mcu_ncu_stall !== 1'b0) begin
      errors++;
      $display("FAIL %s end: vld=%b data=%h stall=%b, required 0 0 0",
               nm, bus.mcu_ncu_vld, bus.mcu_ncu_data, bus.mcu_ncu_stall);
    end
  endtask

  task automatic do_read(input string nm, input logic [3:0] cmd, input logic [7:0] tag,
                         input logic [39:0] addr, input int hold, input int mid);
    build_req(cmd, tag, addr, 64'h0);
    build_exp(cmd, tag, addr);
    send_req(99);
    recv_resp(nm, hold, mid);
    checks++;
    if (err_cnt !== 8'(m_err)) begin
      errors++;
      $display("FAIL %s err_cnt: got %0d, required %0d", nm, err_cnt, m_err);
    end
  endtask

  task automatic do_write(input string nm, input logic [7:0] tag, input logic [39:0] addr,
                          input logic [63:0] data);
    build_req(C_WRITE, tag, addr, data);
    send_req(99);
    checks++;
    if (bus.mcu_ncu_stall !== 1'b1 || bus.mcu_ncu_vld !== 1'b0 || bus.mcu_ncu_data !== 4'h0) begin
      errors++;
      $display("FAIL %s exec: stall=%b vld=%b data=%h, required 1 0 0",
               nm, bus.mcu_ncu_stall, bus.mcu_ncu_vld, bus.mcu_ncu_data);
    end
    step();
    if (addr_valid(addr)) m_csr[int'(addr / 40'd8)] = data;
    else bump_err();
    checks++;
    if (bus.mcu_ncu_stall !== 1'b0 || err_cnt !== 8'(m_err)) begin
      errors++;
      $display("FAIL %s done: stall=%b err_cnt=%0d, required stall=0 err_cnt=%0d",
               nm, bus.mcu_ncu_stall, err_cnt, m_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if (bus.mcu_ncu_stall !== 1'b0 || bus.mcu_ncu_vld !== 1'b0 ||
        bus.mcu_ncu_data !== 4'h0 || err_cnt !== 8'h00) begin
      errors++;
      $display("FAIL reset_hold: stall=%b vld=%b data=%h err=%0d, required all 0",
               bus.mcu_ncu_stall, bus.mcu_ncu_vld, bus.mcu_ncu_data, err_cnt);
    end
    rst = 1'b0;
    step();
    checks++;
    if (bus.mcu_ncu_stall !== 1'b0 || bus.mcu_ncu_vld !== 1'b0 ||
        bus.mcu_ncu_data !== 4'h0 || err_cnt !== 8'h00) begin
      errors++;
      $display("FAIL reset_release: stall=%b vld=%b data=%h err=%0d, required all 0",
               bus.mcu_ncu_stall, bus.mcu_ncu_vld, bus.mcu_ncu_data, err_cnt);
    end
  endtask

  task automatic test_write_read();
    do_write("wr_5a", 8'h5A, 40'h10, 64'hDEADBEEF_CAFEF00D);
    do_read("rd_21", C_READ, 8'h21, 40'h10, 0, 0);
    do_read("rd_rstval", C_READ, 8'hC4, 40'h00, 0, 0);
  endtask

  task automatic test_ifill_nack();
    do_read("ifill_oor", C_IFILL, 8'h03, 40'h40, 0, 0);
    do_read("rd_misalign", C_READ, 8'hE1, 40'h0C, 0, 0);
    do_write("wr_ifill_src", 8'h10, 40'h38, 64'hA5A5_0F0F_1234_5678);
    do_read("ifill_ack", C_IFILL, 8'hB7, 40'h38, 0, 0);
  endtask

  task automatic test_ncu_stall();
    do_write("wr_08", 8'h01, 40'h08, {$urandom, $urandom});
    do_read("rd_stall", C_READ, 8'h6E, 40'h08, 5, 6);
  endtask

  task automatic test_proto_err();
    build_req(C_READ, 8'h77, 40'h10, 64'h0);
    build_exp(C_READ, 8'h77, 40'h10);
    send_req(99);
    fork
      begin
        step();
        step();
        build_req(C_IFILL, 8'h99, 40'h00, 64'h0);
        send_req(99);
      end
      recv_resp("busy_hdr", 0, 0);
    join
    bump_err();
    checks++;
    if (err_cnt !== 8'(m_err)) begin
      errors++;
      $display("FAIL busy_hdr err_cnt: got %0d, required %0d", err_cnt, m_err);
    end
    build_req(4'hF, 8'h12, 40'h00, 64'h0);
    send_req(99);
    step();
    bump_err();
    checks++;
    if (err_cnt !== 8'(m_err) || bus.mcu_ncu_stall !== 1'b0 || bus.mcu_ncu_vld !== 1'b0) begin
      errors++;
      $display("FAIL bad_cmd: err=%0d stall=%b vld=%b, required err=%0d stall=0 vld=0",
               err_cnt, bus.mcu_ncu_stall, bus.mcu_ncu_vld, m_err);
    end
    do_read("after_err", C_READ, 8'h5C, 40'h10, 0, 0);
  endtask

  task automatic test_abandon();
    build_req(C_WRITE, 8'h33, 40'h20, 64'hFFFF_0000_FFFF_0000);
    send_req(8);
    bump_err();
    do_read("abandon", C_READ, 8'h34, 40'h20, 0, 0);
  endtask

  task automatic test_rst_mid();
    build_req(C_WRITE, 8'h44, 40'h10, 64'h1111_2222_3333_4444);
    send_req(20);
    bus.ncu_mcu_data = req_q[20];
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.mcu_ncu_stall !== 1'b0 || bus.mcu_ncu_vld !== 1'b0 ||
        bus.mcu_ncu_data !== 4'h0 || err_cnt !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid: stall=%b vld=%b data=%h err=%0d, required all 0",
               bus.mcu_ncu_stall, bus.mcu_ncu_vld, bus.mcu_ncu_data, err_cnt);
    end
    model_reset();
    bus.ncu_mcu_data = 4'h0;
    step();
    step();
    rst = 1'b0;
    step();
    do_read("rd_after_rst", C_READ, 8'h45, 40'h10, 0, 0);
  endtask

  task automatic test_random();
    logic [63:0] r;
    logic [39:0] addr;
    logic [7:0]  tag;
    int          op;
    for (int it = 0; it < 40; it++) begin
      op  = int'($urandom_range(0, 2));
      tag = 8'($urandom);
      r   = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0:       addr = 40'($urandom_range(0, NREG - 1)) * 40'd8 + 40'($urandom_range(1, 7));
        1:       addr = 40'(NREG + int'($urandom_range(0, 1000))) * 40'd8;
        2:       addr = r[39:0];
        default: addr = 40'($urandom_range(0, NREG - 1)) * 40'd8;
      endcase
      repeat ($urandom_range(0, 2)) step();
      if (op == 0) do_write("rnd_wr", tag, addr, {$urandom, $urandom});
      else do_read("rnd_rd", (op == 1) ? C_READ : C_IFILL, tag, addr,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 12)));
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) do_write("sat_wr", 8'(i), 40'(NREG + i) * 40'd8, 64'(i));
    checks++;
    if (err_cnt !== 8'hFF) begin
      errors++;
      $display("FAIL saturate: err_cnt=%0d, required 255", err_cnt);
    end
    do_read("sat_rd", C_READ, 8'h0A, 40'h10, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst               = 1'b1;
    bus.ncu_mcu_vld   = 1'b0;
    bus.ncu_mcu_data  = 4'h0;
    bus.ncu_mcu_stall = 1'b0;
    model_reset();
    test_reset();
    test_write_read();
    test_ifill_nack();
    test_ncu_stall();
    test_proto_err();
    test_abandon();
    test_rst_mid();
    test_random();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
